// File: rtl/oab_player_ctrl.sv
// Player-side controller for the one-armed-bandit core: keeps the credit balance,
// debits a validated bet, drives roll/bet for one round and credits the result.
module oab_player_ctrl #(
    parameter int CREDIT_W    = 16,
    parameter int INIT_CREDIT = 100,
    parameter int ROLL_CYCLES = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [3:0]          bet_req_i,
    input  logic                cash_out_i,
    output logic                roll_o,
    output logic [3:0]          bet_o,
    input  logic                done_i,
    input  logic                jackpot_i,
    input  logic [CREDIT_W-1:0] payout_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o,
    output logic                reject_o,
    output logic                cash_valid_o,
    output logic [CREDIT_W-1:0] cash_amt_o,
    output logic [7:0]          jackpot_cnt_o,
    output logic                err_timeout_o
);

    localparam int RCW = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RCW-1:0] ROLL_LAST    = RCW'(ROLL_CYCLES - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state_q;
    logic [RCW-1:0]      rollCnt_q;
    logic [TCW-1:0]      waitCnt_q;
    logic                roll_q;
    logic [3:0]          bet_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                busy_q;
    logic                reject_q;
    logic                cashValid_q;
    logic [CREDIT_W-1:0] cashAmt_q;
    logic [7:0]          jackpotCnt_q;
    logic                errTimeout_q;

    logic [CREDIT_W-1:0] betExt;
    logic                betBad;
    logic [CREDIT_W:0]   winSum_d;
    logic [CREDIT_W:0]   refundSum_d;
    logic [CREDIT_W-1:0] creditWin_d;
    logic [CREDIT_W-1:0] creditRefund_d;

    // Sums carry one extra bit so overflow can be clamped to the all-ones balance.
    always_comb begin
        betExt         = CREDIT_W'(bet_req_i);
        betBad         = (bet_req_i == 4'd0) || (betExt > credit_q);
        winSum_d       = {1'b0, credit_q} + {1'b0, payout_i};
        refundSum_d    = {1'b0, credit_q} + {1'b0, CREDIT_W'(bet_q)};
        creditWin_d    = winSum_d[CREDIT_W] ? {CREDIT_W{1'b1}} : winSum_d[CREDIT_W-1:0];
        creditRefund_d = refundSum_d[CREDIT_W] ? {CREDIT_W{1'b1}} : refundSum_d[CREDIT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            rollCnt_q    <= '0;
            waitCnt_q    <= '0;
            roll_q       <= 1'b0;
            bet_q        <= 4'd0;
            credit_q     <= CREDIT_W'(INIT_CREDIT);
            busy_q       <= 1'b0;
            reject_q     <= 1'b0;
            cashValid_q  <= 1'b0;
            cashAmt_q    <= '0;
            jackpotCnt_q <= 8'd0;
            errTimeout_q <= 1'b0;
        end else begin
            reject_q    <= 1'b0;
            cashValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cash_out_i) begin
                        cashAmt_q   <= credit_q;
                        cashValid_q <= 1'b1;
                        credit_q    <= '0;
                    end else if (start_i) begin
                        if (betBad) begin
                            reject_q <= 1'b1;
                        end else begin
                            bet_q     <= bet_req_i;
                            credit_q  <= credit_q - betExt;
                            rollCnt_q <= '0;
                            roll_q    <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= ROLL;
                        end
                    end
                end
                ROLL: begin
                    if (rollCnt_q == ROLL_LAST) begin
                        roll_q    <= 1'b0;
                        waitCnt_q <= '0;
                        state_q   <= WAIT;
                    end else begin
                        rollCnt_q <= rollCnt_q + RCW'(1);
                    end
                end
                WAIT: begin
                    // A result arriving on the expiry cycle still counts as a normal round.
                    if (done_i) begin
                        credit_q <= creditWin_d;
                        if (jackpot_i) begin
                            jackpotCnt_q <= jackpotCnt_q + 8'd1;
                        end
                        bet_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (waitCnt_q == TIMEOUT_LAST) begin
                        credit_q     <= creditRefund_d;
                        errTimeout_q <= 1'b1;
                        bet_q        <= 4'd0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        waitCnt_q <= waitCnt_q + TCW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign roll_o        = roll_q;
    assign bet_o         = bet_q;
    assign credit_o      = credit_q;
    assign busy_o        = busy_q;
    assign reject_o      = reject_q;
    assign cash_valid_o  = cashValid_q;
    assign cash_amt_o    = cashAmt_q;
    assign jackpot_cnt_o = jackpotCnt_q;
    assign err_timeout_o = errTimeout_q;

endmodule

// File: tb/tb_oab_player_ctrl.sv
// Bench for oab_player_ctrl: a round-level model checked every cycle on the default
// instance, plus literal expectations on a narrow CREDIT_W=8 instance.
module tb_oab_player_ctrl;

    localparam int R    = 4;
    localparam int TO   = 64;
    localparam int CMAX = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  betReq = 4'd0;
    logic        cashOut = 1'b0;
    logic        done = 1'b0;
    logic        jackpot = 1'b0;
    logic [15:0] payout = 16'd0;
    logic        roll;
    logic [3:0]  bet;
    logic [15:0] credit;
    logic        busy;
    logic        reject;
    logic        cashValid;
    logic [15:0] cashAmt;
    logic [7:0]  jackpotCnt;
    logic        errTimeout;

    logic        bStart = 1'b0;
    logic [3:0]  bBetReq = 4'd0;
    logic        bCashOut = 1'b0;
    logic        bDone = 1'b0;
    logic        bJackpot = 1'b0;
    logic [7:0]  bPayout = 8'd0;
    logic        bRoll;
    logic [3:0]  bBet;
    logic [7:0]  bCredit;
    logic        bBusy;
    logic        bReject;
    logic        bCashValid;
    logic [7:0]  bCashAmt;
    logic [7:0]  bJackpotCnt;
    logic        bErrTimeout;

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    oab_player_ctrl dutA (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bet_req_i(betReq),
        .cash_out_i(cashOut), .roll_o(roll), .bet_o(bet), .done_i(done),
        .jackpot_i(jackpot), .payout_i(payout), .credit_o(credit), .busy_o(busy),
        .reject_o(reject), .cash_valid_o(cashValid), .cash_amt_o(cashAmt),
        .jackpot_cnt_o(jackpotCnt), .err_timeout_o(errTimeout)
    );

    oab_player_ctrl #(.CREDIT_W(8), .INIT_CREDIT(250), .ROLL_CYCLES(1), .TIMEOUT(2)) dutB (
        .clk_i(clk), .rst_i(rst), .start_i(bStart), .bet_req_i(bBetReq),
        .cash_out_i(bCashOut), .roll_o(bRoll), .bet_o(bBet), .done_i(bDone),
        .jackpot_i(bJackpot), .payout_i(bPayout), .credit_o(bCredit), .busy_o(bBusy),
        .reject_o(bReject), .cash_valid_o(bCashValid), .cash_amt_o(bCashAmt),
        .jackpot_cnt_o(bJackpotCnt), .err_timeout_o(bErrTimeout)
    );

    // Round model: mAge counts cycles since the accepted start (-1 when idle);
    // ages 1..R are roll cycles, age R+k is the k-th cycle spent waiting for done.
    int mCredit = 100;
    int mBet = 0;
    int mAge = -1;
    int mJcnt = 0;
    int mCashAmt = 0;
    bit mReject = 1'b0;
    bit mCashValid = 1'b0;
    bit mErr = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            mCredit = 100; mBet = 0; mAge = -1; mJcnt = 0; mCashAmt = 0;
            mReject = 1'b0; mCashValid = 1'b0; mErr = 1'b0;
        end else begin
            mReject = 1'b0;
            mCashValid = 1'b0;
            if (mAge < 0) begin
                if (cashOut) begin
                    mCashAmt = mCredit; mCashValid = 1'b1; mCredit = 0;
                end else if (start) begin
                    if (betReq == 4'd0 || int'(betReq) > mCredit) begin
                        mReject = 1'b1;
                    end else begin
                        mBet = int'(betReq); mCredit = mCredit - mBet; mAge = 1;
                    end
                end
            end else if (mAge <= R) begin
                mAge++;
            end else if (done) begin
                mCredit = (mCredit + int'(payout) > CMAX) ? CMAX : mCredit + int'(payout);
                if (jackpot) mJcnt = (mJcnt + 1) % 256;
                mBet = 0; mAge = -1;
            end else if (mAge - R == TO) begin
                mCredit = (mCredit + mBet > CMAX) ? CMAX : mCredit + mBet;
                mErr = 1'b1; mBet = 0; mAge = -1;
            end else begin
                mAge++;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("roll", int'(roll), int'(mAge >= 1 && mAge <= R));
            checkOutput("busy", int'(busy), int'(mAge >= 1));
            checkOutput("bet", int'(bet), mBet);
            checkOutput("credit", int'(credit), mCredit);
            checkOutput("reject", int'(reject), int'(mReject));
            checkOutput("cash_valid", int'(cashValid), int'(mCashValid));
            checkOutput("cash_amt", int'(cashAmt), mCashAmt);
            checkOutput("jackpot_cnt", int'(jackpotCnt), mJcnt);
            checkOutput("err_timeout", int'(errTimeout), int'(mErr));
        end
    end

    task automatic applyStimulus(input logic s, input logic [3:0] b, input logic c,
                                 input logic d, input logic j, input logic [15:0] p);
        start = s; betReq = b; cashOut = c; done = d; jackpot = j; payout = p;
        @(posedge clk);
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic applyStimulusB(input logic s, input logic [3:0] b, input logic d,
                                  input logic [7:0] p);
        bStart = s; bBetReq = b; bDone = d; bPayout = p;
        @(posedge clk);
        #1;
    endtask

    // doneAt = wait cycle carrying done (0 = never, round times out).
    task automatic runRound(input int betV, input int doneAt, input bit jp, input int pay,
                            input bit doneInRoll, output int rollCount);
        int total;
        applyStimulus(1'b1, 4'(betV), 1'b0, 1'b0, 1'b0, 16'd0);
        rollCount = roll ? 1 : 0;
        total = R + ((doneAt > 0) ? doneAt : TO);
        for (int i = 1; i <= total; i++) begin
            if (doneAt > 0 && i == total)
                applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, jp, 16'(pay));
            else if (doneInRoll && i == 2)
                applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'd999);
            else
                applyIdle();
            if (roll) rollCount++;
        end
    endtask

    int rc;

    initial begin
        rst = 1'b0;
        applyIdle();
        rst = 1'b1;
        checkEn = 1'b1;
        checkOutput("reset credit", int'(credit), 100);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset jackpot_cnt", int'(jackpotCnt), 0);

        runRound(5, 1, 1'b0, 0, 1'b0, rc);
        checkOutput("t1 roll cycles", rc, 4);
        checkOutput("t1 credit", int'(credit), 95);
        checkOutput("t1 busy", int'(busy), 0);

        runRound(3, 2, 1'b1, 200, 1'b1, rc);
        checkOutput("t2 credit", int'(credit), 292);
        checkOutput("t2 jackpot_cnt", int'(jackpotCnt), 1);

        runRound(7, 0, 1'b0, 0, 1'b0, rc);
        checkOutput("t4 roll cycles", rc, 4);
        checkOutput("t4 credit", int'(credit), 292);
        checkOutput("t4 err_timeout", int'(errTimeout), 1);
        checkOutput("t4 busy", int'(busy), 0);

        // start held high through a whole round re-arms on the first idle cycle
        for (int i = 0; i < R + 2; i++) applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 16'd0);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 16'd0);
        checkOutput("hold idle credit", int'(credit), 290);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 16'd0);
        checkOutput("hold rearm busy", int'(busy), 1);
        checkOutput("hold rearm credit", int'(credit), 288);
        for (int i = 0; i < R; i++) applyIdle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd0);
        checkOutput("hold end credit", int'(credit), 288);

        for (int i = 0; i < 18; i++) runRound(15, 1, 1'b0, 0, 1'b0, rc);
        runRound(14, 1, 1'b0, 0, 1'b0, rc);
        checkOutput("drain credit", int'(credit), 4);

        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 16'd0);
        checkOutput("t3 reject over", int'(reject), 1);
        checkOutput("t3 credit", int'(credit), 4);
        checkOutput("t3 roll", int'(roll), 0);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        checkOutput("t3 reject zero", int'(reject), 1);
        applyIdle();
        checkOutput("t3 reject pulse", int'(reject), 0);

        runRound(4, 1, 1'b0, 50, 1'b0, rc);
        checkOutput("bet eq credit", int'(credit), 50);

        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 16'd0);
        checkOutput("t6 cash_valid", int'(cashValid), 1);
        checkOutput("t6 cash_amt", int'(cashAmt), 50);
        checkOutput("t6 credit", int'(credit), 0);
        checkOutput("t6 busy", int'(busy), 0);
        applyIdle();
        checkOutput("t6 cash pulse", int'(cashValid), 0);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'd0);
        checkOutput("zero credit reject", int'(reject), 1);

        rst = 1'b0;
        applyIdle();
        rst = 1'b1;
        checkOutput("rst credit", int'(credit), 100);
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < R + 3; i++) applyIdle();
        checkOutput("midwait busy", int'(busy), 1);
        rst = 1'b0;
        applyIdle();
        rst = 1'b1;
        checkOutput("midwait rst credit", int'(credit), 100);
        checkOutput("midwait rst busy", int'(busy), 0);
        checkOutput("midwait rst bet", int'(bet), 0);
        checkOutput("midwait rst err", int'(errTimeout), 0);

        for (int i = 0; i < 255; i++) runRound(1, 1, 1'b1, 1, 1'b0, rc);
        checkOutput("jackpot 255", int'(jackpotCnt), 255);
        runRound(1, 1, 1'b1, 1, 1'b0, rc);
        checkOutput("jackpot wrap", int'(jackpotCnt), 0);
        checkOutput("jackpot credit", int'(credit), 100);

        applyStimulusB(1'b1, 4'd10, 1'b0, 8'd0);
        checkOutput("B credit after bet", int'(bCredit), 240);
        checkOutput("B roll", int'(bRoll), 1);
        checkOutput("B bet", int'(bBet), 10);
        applyStimulusB(1'b0, 4'd0, 1'b0, 8'd0);
        checkOutput("B roll one cycle", int'(bRoll), 0);
        checkOutput("B busy wait", int'(bBusy), 1);
        applyStimulusB(1'b0, 4'd0, 1'b1, 8'd100);
        checkOutput("B saturated credit", int'(bCredit), 255);
        checkOutput("B busy idle", int'(bBusy), 0);
        applyStimulusB(1'b1, 4'd5, 1'b0, 8'd0);
        checkOutput("B credit bet5", int'(bCredit), 250);
        applyStimulusB(1'b0, 4'd0, 1'b0, 8'd0);
        applyStimulusB(1'b0, 4'd0, 1'b0, 8'd0);
        checkOutput("B busy before expiry", int'(bBusy), 1);
        checkOutput("B err before expiry", int'(bErrTimeout), 0);
        applyStimulusB(1'b0, 4'd0, 1'b0, 8'd0);
        checkOutput("B refund credit", int'(bCredit), 255);
        checkOutput("B err_timeout", int'(bErrTimeout), 1);
        checkOutput("B busy after expiry", int'(bBusy), 0);

        applyIdle();
        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
